mantissa_normalizer: RTL and testbench
======================================

// Module: mantissa_normalizer
// PURPOSE
//  Two-stage pipelined normalizer downstream of the unpacker's leading-zero counter.
//  Takes an unpacked significand and exponent, counts leading zeros, and left-shifts the significand until its MSB is 1.
//  Subtracts the shift amount from the exponent.
//  Feeds the FPU datapath over a valid/ready handshake and flags exact-zero operands.
// PARAMETERS
//  N    64  significand width, power of two, >= 4
//  M    6   log2(N); the lz count is M+1 bits
//  E    13  input exponent width, signed two's complement
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    synchronous active-high reset
//  in_valid   in   1    input operand valid
//  in_ready   out  1    block can accept an operand this cycle
//  in_sign    in   1    operand sign (passed through)
//  in_exp     in   E    operand exponent, signed
//  in_mant    in   N    operand significand, unnormalized
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer accepts result this cycle
//  out_sign   out  1    sign, unchanged
//  out_exp    out  E+1  normalized exponent = in_exp - lz, signed
//  out_mant   out  N    normalized significand, MSB=1 unless out_zero
//  out_lz     out  M+1  shift amount applied (N when operand is zero)
//  out_zero   out  1    operand significand was all zeros
// BEHAVIOUR
//  - Reset: s1_valid=0, s2_valid=0, out_valid=0. out_sign, out_exp, out_mant, out_lz and out_zero are all 0. in_ready=1 in the cycle after rst falls.
//  - rst takes priority over every handshake. Operands in flight are dropped with no partial output, and out_valid is 0 in the cycle after rst.
//  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//  - Stage 1 (S1) captures sign, exp and mant on input transfer, plus the lz count.
//    - lz = number of leading zeros of in_mant, range 0..N. lz=N iff in_mant==0.
//    - lz is computed combinationally from in_mant before the S1 register.
//  - Stage 2 (S2) takes S1 contents on S1->S2 advance and computes:
//    - mant = s1_mant << s1_lz, truncated to N bits; 0 when lz=N.
//    - exp = sext(s1_exp, E+1) - s1_lz, without saturation. Range is guaranteed by E+1 bits.
//    - zero = (s1_lz == N). When zero=1, exp is forced to 0.
//  - The outputs are the S2 registers directly, with no combinational path from in_* to out_*.
//  - Latency: 2 cycles from input transfer to out_valid with no stalls. Throughput is 1 operand per cycle.
//  - Advance rules:
//    - s2_adv = s1_valid & (~s2_valid | out_ready)
//    - s1_adv (= in_ready) = ~s1_valid | s2_adv
//  - in_ready depends on out_ready combinationally. That is the only comb path.
//  - Stall: out_valid & ~out_ready holds all out_* stable. S1 holds if full. in_ready=0 once both stages are full.
//  - Simultaneous events:
//    - S2 drained and refilled in the same cycle: the new S2 value is visible the next cycle and out_valid stays 1.
//    - S1 drained and refilled in the same cycle is legal.
//  - If s2_valid=0 and no S1->S2 advance occurs, S2 data registers keep their old values. Only out_valid qualifies them.
//  - No operand may be dropped or duplicated. Output order equals input order.
// TESTING
//  1) N=64,E=13, mant=0x0000_0000_0000_0001, exp=10, sign=1, out_ready=1
//     -> two cycles later: mant=0x8000_0000_0000_0000, exp=-53, lz=63, zero=0, sign=1.
//  2) mant=0x8000_0000_0000_0000, exp=-1022 -> mant unchanged, lz=0, exp=-1022.
//  3) mant=0, exp=100 -> lz=64, zero=1, mant=0, exp=0.
//  4) Stream 0x1,0x2,0x4,0x8 with exp=0 on back-to-back cycles, out_ready=1
//     -> four consecutive out_valid cycles, each mant=0x8000...0. exp = -63, -62, -61, -60.
//  5) Drive 3 operands with out_ready=0
//     -> in_ready falls after 2 accepted operands. Outputs hold. On raising out_ready, all 3 emerge in order with no gap once flowing.
//  6) rst asserted for 1 cycle with both stages full
//     -> next cycle out_valid=0, all out_*=0, in_ready=1. The next operand appears after 2 cycles.

Source files
------------

// File: rtl/mantissa_normalizer.sv
// Two-stage pipelined significand normalizer: S1 registers the operand with its
// leading-zero count, S2 registers the left-shifted significand and adjusted exponent.
module mantissa_normalizer #(
    parameter int unsigned N = 64,
    parameter int unsigned M = 6,
    parameter int unsigned E = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [E-1:0] in_exp,
    input  logic [N-1:0] in_mant,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [E:0]   out_exp,
    output logic [N-1:0] out_mant,
    output logic [M:0]   out_lz,
    output logic         out_zero
);

    localparam int unsigned LzW = M + 1;
    localparam logic [LzW-1:0] LzAllZero = LzW'(N);

    logic           r_s1_valid;
    logic           r_s1_sign;
    logic [E-1:0]   r_s1_exp;
    logic [N-1:0]   r_s1_mant;
    logic [LzW-1:0] r_s1_lz;

    logic           r_s2_valid;
    logic           r_s2_sign;
    logic [E:0]     r_s2_exp;
    logic [N-1:0]   r_s2_mant;
    logic [LzW-1:0] r_s2_lz;
    logic           r_s2_zero;

    logic           w_s2_adv;
    logic           w_s1_adv;
    logic           w_in_xfer;
    logic [LzW-1:0] w_lz;
    logic [N-1:0]   w_norm_mant;
    logic [E:0]     w_norm_exp;
    logic           w_norm_zero;

    assign w_s2_adv  = r_s1_valid & (~r_s2_valid | out_ready);
    assign w_s1_adv  = ~r_s1_valid | w_s2_adv;
    assign w_in_xfer = in_valid & w_s1_adv;

    // Scan LSB to MSB so the highest set bit wins; stays N when in_mant is zero.
    always_comb begin
        w_lz = LzAllZero;
        for (int i = 0; i < N; i++) begin
            if (in_mant[i]) begin
                w_lz = LzW'(N - 1 - i);
            end
        end
    end

    always_comb begin
        w_norm_zero = (r_s1_lz == LzAllZero);
        w_norm_mant = r_s1_mant << r_s1_lz;
        w_norm_exp  = {r_s1_exp[E-1], r_s1_exp} - (E+1)'(r_s1_lz);
        if (w_norm_zero) begin
            w_norm_exp = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s1_lz    <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_xfer) begin
                r_s1_sign <= in_sign;
                r_s1_exp  <= in_exp;
                r_s1_mant <= in_mant;
                r_s1_lz   <= w_lz;
            end
        end
    end

    // S2 data only loads on advance; out_valid alone qualifies it otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
            r_s2_lz    <= '0;
            r_s2_zero  <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_sign  <= r_s1_sign;
                r_s2_exp   <= w_norm_exp;
                r_s2_mant  <= w_norm_mant;
                r_s2_lz    <= r_s1_lz;
                r_s2_zero  <= w_norm_zero;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_sign  = r_s2_sign;
    assign out_exp   = r_s2_exp;
    assign out_mant  = r_s2_mant;
    assign out_lz    = r_s2_lz;
    assign out_zero  = r_s2_zero;

endmodule

// File: tb/tb_mantissa_normalizer.sv
// Directed bench for mantissa_normalizer: single operands, streaming, backpressure
// and reset with a full pipeline, all expected values computed by hand.
module tb_mantissa_normalizer;

    localparam int unsigned N = 64;
    localparam int unsigned M = 6;
    localparam int unsigned E = 13;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_sign;
    logic [E-1:0] in_exp;
    logic [N-1:0] in_mant;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [E:0]   out_exp;
    logic [N-1:0] out_mant;
    logic [M:0]   out_lz;
    logic         out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    mantissa_normalizer #(.N(N), .M(M), .E(E)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sign  (in_sign),
        .in_exp   (in_exp),
        .in_mant  (in_mant),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sign (out_sign),
        .out_exp  (out_exp),
        .out_mant (out_mant),
        .out_lz   (out_lz),
        .out_zero (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] e14(input int v);
        logic [13:0] t;
        t = v[13:0];
        return {50'b0, t};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input int e, input logic [N-1:0] m);
        in_valid = v;
        in_sign  = s;
        in_exp   = e[E-1:0];
        in_mant  = m;
    endtask

    task automatic check_out(input string tag, input logic s, input int e,
                             input logic [N-1:0] m, input int lz, input logic z);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sign"},  64'(out_sign), 64'(s));
        check({tag, ".exp"},   64'(out_exp), e14(e));
        check({tag, ".mant"},  out_mant, m);
        check({tag, ".lz"},    64'(out_lz), 64'(lz));
        check({tag, ".zero"},  64'(out_zero), 64'(z));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 0, '0);
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.sign",  64'(out_sign), 64'd0);
        check("rst.exp",   64'(out_exp), 64'd0);
        check("rst.mant",  out_mant, 64'd0);
        check("rst.lz",    64'(out_lz), 64'd0);
        check("rst.zero",  64'(out_zero), 64'd0);
        rst = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // single operand, lowest bit set
        drive(1'b1, 1'b1, 10, 64'h1);
        tick();
        drive(1'b0, 1'b0, 0, '0);
        check("t1.latency", 64'(out_valid), 64'd0);
        tick();
        check_out("t1", 1'b1, -53, 64'h8000_0000_0000_0000, 63, 1'b0);

        drive(1'b1, 1'b0, -1022, 64'h8000_0000_0000_0000);
        tick();
        drive(1'b0, 1'b0, 0, '0);
        tick();
        check_out("t2", 1'b0, -1022, 64'h8000_0000_0000_0000, 0, 1'b0);

        drive(1'b1, 1'b0, 100, 64'h0);
        tick();
        drive(1'b0, 1'b0, 0, '0);
        tick();
        check_out("t3", 1'b0, 0, 64'h0, 64, 1'b1);
        tick();
        check("t3.drain", 64'(out_valid), 64'd0);

        // back-to-back stream
        drive(1'b1, 1'b0, 0, 64'h1);
        tick();
        drive(1'b1, 1'b0, 0, 64'h2);
        tick();
        check_out("t4a", 1'b0, -63, 64'h8000_0000_0000_0000, 63, 1'b0);
        drive(1'b1, 1'b0, 0, 64'h4);
        tick();
        check_out("t4b", 1'b0, -62, 64'h8000_0000_0000_0000, 62, 1'b0);
        drive(1'b1, 1'b0, 0, 64'h8);
        tick();
        check_out("t4c", 1'b0, -61, 64'h8000_0000_0000_0000, 61, 1'b0);
        drive(1'b0, 1'b0, 0, '0);
        tick();
        check_out("t4d", 1'b0, -60, 64'h8000_0000_0000_0000, 60, 1'b0);
        tick();
        check("t4.drain", 64'(out_valid), 64'd0);

        // backpressure: three operands with consumer stalled
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 5, 64'h10);
        #1;
        check("t5.rdyA", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 1'b1, 0, 64'h0000_0001_0000_0000);
        #1;
        check("t5.rdyB", 64'(in_ready), 64'd1);
        tick();
        drive(1'b1, 1'b0, -3, 64'h00F0_0000_0000_0000);
        #1;
        check("t5.rdyC0", 64'(in_ready), 64'd0);
        check_out("t5.holdA0", 1'b0, -54, 64'h8000_0000_0000_0000, 59, 1'b0);
        tick();
        check("t5.rdyC1", 64'(in_ready), 64'd0);
        check_out("t5.holdA1", 1'b0, -54, 64'h8000_0000_0000_0000, 59, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t5.rdyC2", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, 1'b0, 0, '0);
        check_out("t5.B", 1'b1, -31, 64'h8000_0000_0000_0000, 31, 1'b0);
        tick();
        check_out("t5.C", 1'b0, -11, 64'hF000_0000_0000_0000, 8, 1'b0);
        tick();
        check("t5.drain", 64'(out_valid), 64'd0);

        // reset with both stages full
        out_ready = 1'b0;
        drive(1'b1, 1'b1, 7, 64'h5);
        tick();
        drive(1'b1, 1'b1, 9, 64'h6);
        tick();
        check("t6.full", 64'(out_valid), 64'd1);
        drive(1'b0, 1'b0, 0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t6.valid", 64'(out_valid), 64'd0);
        check("t6.sign",  64'(out_sign), 64'd0);
        check("t6.exp",   64'(out_exp), 64'd0);
        check("t6.mant",  out_mant, 64'd0);
        check("t6.lz",    64'(out_lz), 64'd0);
        check("t6.zero",  64'(out_zero), 64'd0);
        check("t6.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 2, 64'h3);
        tick();
        drive(1'b0, 1'b0, 0, '0);
        check("t6.lat", 64'(out_valid), 64'd0);
        tick();
        check_out("t6.F", 1'b1, -60, 64'hC000_0000_0000_0000, 62, 1'b0);
        tick();
        check("t6.drain", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
